// File: rtl/usb_seq_pkg.sv
// Shared definitions for the FT245-style USB FIFO sequencer.
//   - seq_state_e : 4-bit FSM state encoding, also exported on state_out
//   - TAG_W, FIFO_DATA_W : report byte layout and FIFO bus width
//   - cnt_width() : width of the shared strobe/recovery down-counter
package usb_seq_pkg;

  localparam int TAG_W       = 4;
  localparam int FIFO_DATA_W = 8;

  typedef enum logic [3:0] {
    S_IDLE       = 4'd0,
    S_RD_STROBE  = 4'd1,
    S_RD_RECOVER = 4'd2,
    S_WR_WAIT    = 4'd3,
    S_WR_SETUP   = 4'd4,
    S_WR_STROBE  = 4'd5,
    S_WR_HOLD    = 4'd6,
    S_DONE       = 4'd7
  } seq_state_e;

  // The counter is loaded with (cycles - 1), so it must hold max-1.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m <= 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/usb_strobe_timer.sv
// Loadable down-counter timing the multi-cycle sequencer states.
//   clk, reset_n : clock, asynchronous active-low reset
//   load_i       : load load_val_i this cycle (takes priority over counting)
//   load_val_i   : value loaded; a state lasting N cycles loads N-1
//   expired_o    : counter is zero, i.e. this is the last cycle of the state
module usb_strobe_timer #(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic             expired_o
);

  logic [CNT_W-1:0] cnt_q;

  // NOTE: sequential state is always updated with non-blocking assignments so
  // every register samples pre-edge values, independent of block ordering.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/usb_fifo_sequencer.sv
// Sequencer for an FT245-style parallel USB FIFO.
//   Host->cube : reads one byte (rxf_n/rd_n) into cmd_data, handed to the
//                command decoder with cmd_valid/cmd_ready; no new read while
//                a byte is unconsumed.
//   Cube->host : on report_request, snapshots report_data and writes
//                NUM_GROUPS bytes {tag=k+1, group k} (txe_n/wr_n), then
//                pulses report_done.
//   All FIFO-side outputs (rd_n, wr_n, data_out, data_out_enable) are registers.
//   busy / state_out expose the FSM state for status and debug.
module usb_fifo_sequencer
  import usb_seq_pkg::*;
#(
  parameter int NUM_GROUPS    = 4,
  parameter int STROBE_CYCLES = 2,
  parameter int SETUP_CYCLES  = 1,
  parameter int HOLD_CYCLES   = 1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    rxf_n,
  input  logic                    txe_n,
  input  logic [7:0]              data_in,
  output logic [7:0]              data_out,
  output logic                    data_out_enable,
  output logic                    rd_n,
  output logic                    wr_n,
  input  logic                    report_request,
  input  logic [4*NUM_GROUPS-1:0] report_data,
  output logic [7:0]              cmd_data,
  output logic                    cmd_valid,
  input  logic                    cmd_ready,
  output logic                    report_done,
  output logic                    busy,
  output logic [3:0]              state_out
);

  if (NUM_GROUPS < 1 || NUM_GROUPS > 15 || STROBE_CYCLES < 1 ||
      SETUP_CYCLES < 1 || HOLD_CYCLES < 1) begin : g_param_check
    $fatal(1, "usb_fifo_sequencer: illegal parameter set");
  end

  localparam int CNT_W = cnt_width(STROBE_CYCLES, SETUP_CYCLES, HOLD_CYCLES);
  localparam logic [CNT_W-1:0] STROBE_LD = CNT_W'(STROBE_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETUP_LD  = CNT_W'(SETUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LD   = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [3:0]       LAST_K    = 4'(NUM_GROUPS - 1);

  seq_state_e                state_q;
  logic                      rd_n_q, wr_n_q, oe_q, done_q, cmd_valid_q;
  logic [FIFO_DATA_W-1:0]    data_out_q, cmd_data_q;
  logic [4*NUM_GROUPS-1:0]   snap_q;
  logic [3:0]                k_q;

  logic                      tmr_load, tmr_expired;
  logic [CNT_W-1:0]          tmr_val;

  // Report byte k: tag k+1 in the high nibble lets the host resynchronise.
  function automatic logic [7:0] report_byte(input logic [3:0] k,
                                             input logic [4*NUM_GROUPS-1:0] snap);
    logic [TAG_W-1:0] tag;
    tag = k + 4'd1;
    return {tag, snap[4*k +: 4]};
  endfunction

  usb_strobe_timer #(.CNT_W(CNT_W)) u_timer (
    .clk        (clk),
    .reset_n    (reset_n),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .expired_o  (tmr_expired)
  );

  // Timer reload on entry to each timed state; conditions mirror the FSM
  // transitions below.
  always_comb begin
    // NOTE: defaults first so no path leaves a signal unassigned (no latch).
    tmr_load = 1'b0;
    tmr_val  = '0;
    case (state_q)
      S_IDLE: begin
        if (!report_request && !rxf_n && !cmd_valid_q) begin
          tmr_load = 1'b1;
          tmr_val  = STROBE_LD;
        end
      end
      S_RD_STROBE: begin
        tmr_load = tmr_expired;
        tmr_val  = HOLD_LD;
      end
      S_WR_WAIT: begin
        tmr_load = !txe_n;
        tmr_val  = SETUP_LD;
      end
      S_WR_SETUP: begin
        tmr_load = tmr_expired;
        tmr_val  = STROBE_LD;
      end
      S_WR_STROBE: begin
        tmr_load = tmr_expired;
        tmr_val  = HOLD_LD;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      rd_n_q      <= 1'b1;
      wr_n_q      <= 1'b1;
      oe_q        <= 1'b0;
      done_q      <= 1'b0;
      data_out_q  <= '0;
      cmd_data_q  <= '0;
      cmd_valid_q <= 1'b0;
      snap_q      <= '0;
      k_q         <= '0;
    end else begin
      done_q <= 1'b0;
      // A capture can only start with cmd_valid low, so clear and set never
      // collide.
      if (cmd_valid_q && cmd_ready) cmd_valid_q <= 1'b0;

      case (state_q)
        S_IDLE: begin
          if (report_request) begin
            state_q    <= S_WR_WAIT;
            snap_q     <= report_data;
            k_q        <= '0;
            data_out_q <= report_byte(4'd0, report_data);
            oe_q       <= 1'b1;
          end else if (!rxf_n && !cmd_valid_q) begin
            state_q <= S_RD_STROBE;
            rd_n_q  <= 1'b0;
          end
        end
        S_RD_STROBE: begin
          if (tmr_expired) begin
            cmd_data_q  <= data_in;
            cmd_valid_q <= 1'b1;
            rd_n_q      <= 1'b1;
            state_q     <= S_RD_RECOVER;
          end
        end
        S_RD_RECOVER: begin
          if (tmr_expired) state_q <= S_IDLE;
        end
        S_WR_WAIT: begin
          if (!txe_n) state_q <= S_WR_SETUP;
        end
        S_WR_SETUP: begin
          if (tmr_expired) begin
            wr_n_q  <= 1'b0;
            state_q <= S_WR_STROBE;
          end
        end
        S_WR_STROBE: begin
          if (tmr_expired) begin
            wr_n_q  <= 1'b1;
            state_q <= S_WR_HOLD;
          end
        end
        S_WR_HOLD: begin
          if (tmr_expired) begin
            if (k_q == LAST_K) begin
              oe_q    <= 1'b0;
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              k_q        <= k_q + 4'd1;
              data_out_q <= report_byte(k_q + 4'd1, snap_q);
              state_q    <= S_WR_WAIT;
            end
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign data_out        = data_out_q;
  assign data_out_enable = oe_q;
  assign rd_n            = rd_n_q;
  assign wr_n            = wr_n_q;
  assign cmd_data        = cmd_data_q;
  assign cmd_valid       = cmd_valid_q;
  assign report_done     = done_q;
  assign busy            = (state_q != S_IDLE);
  assign state_out       = state_q;

endmodule

// File: tb/tb_usb_fifo_sequencer.sv
// Directed bench: DUT a uses default parameters, DUT b uses NUM_GROUPS=2,
// STROBE_CYCLES=3.
module tb_usb_fifo_sequencer;
  import usb_seq_pkg::*;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  // DUT a (defaults)
  logic        rxf_n_a = 1'b1, txe_n_a = 1'b1, req_a = 1'b0, cmd_ready_a = 1'b0;
  logic [7:0]  data_in_a = 8'h00;
  logic [15:0] rep_a = 16'h0000;
  logic [7:0]  data_out_a, cmd_data_a;
  logic        oe_a, rd_n_a, wr_n_a, cmd_valid_a, done_a, busy_a;
  logic [3:0]  state_a;

  // DUT b (2 groups, 3-cycle strobe)
  logic        rxf_n_b = 1'b1, txe_n_b = 1'b1, req_b = 1'b0, cmd_ready_b = 1'b0;
  logic [7:0]  data_in_b = 8'h00;
  logic [7:0]  rep_b = 8'h00;
  logic [7:0]  data_out_b, cmd_data_b;
  logic        oe_b, rd_n_b, wr_n_b, cmd_valid_b, done_b, busy_b;
  logic [3:0]  state_b;

  usb_fifo_sequencer u_dut_a (
    .clk(clk), .reset_n(reset_n), .rxf_n(rxf_n_a), .txe_n(txe_n_a),
    .data_in(data_in_a), .data_out(data_out_a), .data_out_enable(oe_a),
    .rd_n(rd_n_a), .wr_n(wr_n_a), .report_request(req_a), .report_data(rep_a),
    .cmd_data(cmd_data_a), .cmd_valid(cmd_valid_a), .cmd_ready(cmd_ready_a),
    .report_done(done_a), .busy(busy_a), .state_out(state_a)
  );

  usb_fifo_sequencer #(.NUM_GROUPS(2), .STROBE_CYCLES(3)) u_dut_b (
    .clk(clk), .reset_n(reset_n), .rxf_n(rxf_n_b), .txe_n(txe_n_b),
    .data_in(data_in_b), .data_out(data_out_b), .data_out_enable(oe_b),
    .rd_n(rd_n_b), .wr_n(wr_n_b), .report_request(req_b), .report_data(rep_b),
    .cmd_data(cmd_data_b), .cmd_valid(cmd_valid_b), .cmd_ready(cmd_ready_b),
    .report_done(done_b), .busy(busy_b), .state_out(state_b)
  );

  // Write-path view of the DUT selected by sel (0 = a, 1 = b).
  logic       sel = 1'b0;
  logic       w_wr_n, w_done;
  logic [7:0] w_dout;
  logic [3:0] w_state;
  assign w_wr_n  = sel ? wr_n_b     : wr_n_a;
  assign w_done  = sel ? done_b     : done_a;
  assign w_dout  = sel ? data_out_b : data_out_a;
  assign w_state = sel ? state_b    : state_a;

  int errors = 0;
  int checks = 0;

  logic [7:0] got_bytes[$];
  int         got_lens[$];
  int         done_cycles, rd_lows, unstable, stall_err;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_txe(input logic v);
    if (sel) txe_n_b = v;
    else     txe_n_a = v;
  endtask

  // Follows a report already in WR_WAIT until report_done (or budget expiry).
  // stall_idx > 0 holds txe_n high for 10 cycles before that byte number.
  task automatic watch_report(input int budget, input int stall_idx, input logic [7:0] stall_byte);
    int         cycles, low, bytes_done, stall_left;
    logic [7:0] cur, low_data;
    logic       prev_wr, seen_done, expect_setup;
    cycles = 0; low = 0; bytes_done = 0; stall_left = 0;
    cur = w_dout; low_data = 8'h00;
    prev_wr = 1'b1; seen_done = 1'b0; expect_setup = 1'b0;
    got_bytes.delete();
    got_lens.delete();
    done_cycles = 0; rd_lows = 0; unstable = 0; stall_err = 0;
    while (cycles < budget && !seen_done) begin
      step();
      cycles++;
      if (expect_setup) begin
        check("stall_resume", w_state, S_WR_SETUP);
        expect_setup = 1'b0;
      end
      if (stall_left > 0) begin
        if (w_state != S_WR_WAIT || w_wr_n !== 1'b1 || w_dout !== stall_byte) stall_err++;
        stall_left--;
        if (stall_left == 0) begin
          set_txe(1'b0);
          expect_setup = 1'b1;
        end
      end
      if (w_state == S_WR_WAIT) cur = w_dout;
      else if ((w_state == S_WR_SETUP || w_state == S_WR_STROBE || w_state == S_WR_HOLD)
               && w_dout !== cur) unstable++;
      if (w_wr_n == 1'b0) begin
        low++;
        low_data = w_dout;
      end else if (!prev_wr) begin
        got_bytes.push_back(low_data);
        got_lens.push_back(low);
        low = 0;
        bytes_done++;
        if (stall_idx > 0 && bytes_done == stall_idx - 1) begin
          set_txe(1'b1);
          stall_left = 10;
        end
      end
      prev_wr = w_wr_n;
      if (!sel && rd_n_a == 1'b0) rd_lows++;
      if (w_done) begin
        seen_done   = 1'b1;
        done_cycles = cycles;
      end
    end
    check("report_done_seen", seen_done, 1'b1);
  endtask

  task automatic check_report(input string tag, input int n, input logic [31:0] exp_bytes,
                              input int exp_len, input int exp_done);
    logic [31:0] eb;
    eb = exp_bytes;
    check({tag, "_nbytes"}, got_bytes.size(), n);
    for (int i = 0; i < n && i < got_bytes.size(); i++) begin
      check($sformatf("%s_byte%0d", tag, i), got_bytes[i], eb[8*i +: 8]);
      check($sformatf("%s_len%0d", tag, i), got_lens[i], exp_len);
    end
    check({tag, "_done_cycle"}, done_cycles, exp_done);
    check({tag, "_data_stable"}, unstable, 0);
  endtask

  task automatic wait_cmd_a(input string tag, input logic [7:0] exp);
    logic got;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      step();
      if (cmd_valid_a) got = 1'b1;
    end
    check({tag, "_valid"}, got, 1'b1);
    check({tag, "_data"}, cmd_data_a, exp);
  endtask

  task automatic consume_a();
    cmd_ready_a = 1'b1;
    step();
    cmd_ready_a = 1'b0;
    check("consume_clears_valid", cmd_valid_a, 1'b0);
  endtask

  initial begin
    int lows, rises;
    logic got, prev;

    // ---- reset state ----
    repeat (2) @(posedge clk);
    #1;
    check("rst_rd_n", rd_n_a, 1'b1);
    check("rst_wr_n", wr_n_a, 1'b1);
    check("rst_oe", oe_a, 1'b0);
    check("rst_data_out", data_out_a, 8'h00);
    check("rst_cmd_valid", cmd_valid_a, 1'b0);
    check("rst_cmd_data", cmd_data_a, 8'h00);
    check("rst_done", done_a, 1'b0);
    check("rst_busy", busy_a, 1'b0);
    check("rst_state", state_a, S_IDLE);
    reset_n = 1'b1;
    step();
    check("idle_after_release", state_a, S_IDLE);

    // ---- read: strobe width, capture, backpressure ----
    data_in_a = 8'hA5;
    rxf_n_a   = 1'b0;
    lows = 0; got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      step();
      if (rd_n_a == 1'b0) lows++;
      if (cmd_valid_a) got = 1'b1;
    end
    check("rd_captured", got, 1'b1);
    check("rd_low_cycles", lows, 2);
    check("rd_n_high_at_capture", rd_n_a, 1'b1);
    check("rd_cmd_data", cmd_data_a, 8'hA5);
    check("rd_recover_state", state_a, S_RD_RECOVER);
    data_in_a = 8'h3C;
    lows = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (rd_n_a == 1'b0) lows++;
    end
    check("backpressure_no_read", lows, 0);
    check("backpressure_valid_held", cmd_valid_a, 1'b1);
    consume_a();
    check("no_read_same_cycle", rd_n_a, 1'b1);
    step();
    check("next_read_starts", rd_n_a, 1'b0);
    wait_cmd_a("rd2", 8'h3C);
    rxf_n_a = 1'b1;
    consume_a();

    // ---- report with read pending: write wins, snapshot protects data ----
    rep_a     = 16'h4321;
    txe_n_a   = 1'b0;
    data_in_a = 8'h5A;
    rxf_n_a   = 1'b0;
    req_a     = 1'b1;
    step();
    check("prio_state_wr_wait", state_a, S_WR_WAIT);
    check("prio_no_rd", rd_n_a, 1'b1);
    check("wr_first_byte", data_out_a, 8'h11);
    check("wr_oe_on", oe_a, 1'b1);
    check("wr_busy", busy_a, 1'b1);
    rep_a = 16'hFFFF;
    watch_report(60, 0, 8'h00);
    req_a = 1'b0;
    check_report("rep", 4, 32'h44332211, 2, 20);
    check("rep_no_read_during", rd_lows, 0);
    check("rep_done_oe_off", oe_a, 1'b0);
    step();
    check("rep_done_one_cycle", done_a, 1'b0);
    wait_cmd_a("rd_after_rep", 8'h5A);
    rxf_n_a = 1'b1;
    consume_a();

    // ---- txe_n stall before byte 3 ----
    rep_a   = 16'h8765;
    txe_n_a = 1'b0;
    req_a   = 1'b1;
    step();
    check("stall_state_wr_wait", state_a, S_WR_WAIT);
    watch_report(80, 3, 8'h37);
    req_a = 1'b0;
    check_report("stall", 4, 32'h48372615, 2, 29);
    check("stall_hold", stall_err, 0);
    step();

    // ---- reset during WR_STROBE of byte 2 ----
    rep_a   = 16'hBEEF;
    txe_n_a = 1'b0;
    req_a   = 1'b1;
    rises = 0; got = 1'b0; prev = 1'b1;
    for (int i = 0; i < 30 && !got; i++) begin
      step();
      if (prev == 1'b0 && wr_n_a == 1'b1) rises++;
      if (rises == 1 && wr_n_a == 1'b0) got = 1'b1;
      prev = wr_n_a;
    end
    check("rst_mid_reached_byte2", got, 1'b1);
    check("rst_mid_strobe_state", state_a, S_WR_STROBE);
    reset_n = 1'b0;
    #1;
    check("rst_mid_wr_n", wr_n_a, 1'b1);
    check("rst_mid_oe", oe_a, 1'b0);
    check("rst_mid_state", state_a, S_IDLE);
    req_a = 1'b0;
    step();
    reset_n = 1'b1;
    lows = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (done_a || state_a != S_IDLE) lows++;
    end
    check("rst_mid_quiet_after", lows, 0);

    // ---- DUT b: 2 groups, 3-cycle strobe ----
    sel     = 1'b1;
    rep_b   = 8'hF0;
    txe_n_b = 1'b0;
    req_b   = 1'b1;
    step();
    check("b_state_wr_wait", state_b, S_WR_WAIT);
    check("b_first_byte", data_out_b, 8'h10);
    watch_report(40, 0, 8'h00);
    req_b = 1'b0;
    check_report("b", 2, 32'h00002F10, 3, 12);
    step();
    check("b_idle_after", state_b, S_IDLE);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/usb_fifo_sequencer.md
Name: usb_fifo_sequencer

Overview:
Parametrised successor to the panel-switch USB sequencer for the FT245-style parallel USB FIFO.
- Host-to-cube path: reads bytes from the FIFO (rxf_n / rd_n) into a one-entry command holding register with a valid/ready handshake toward the command decoder.
- Cube-to-host path: on request, writes a report of NUM_GROUPS tagged nibble bytes (txe_n / wr_n).
- Compared with the previous generation: group count and strobe timing are parameters, all FIFO controls are registered, the report is snapshotted, and command reads are backpressured.

Parameters:
NUM_GROUPS, 4, number of 4-bit report groups; legal range 1..15.
STROBE_CYCLES, 2, rd_n/wr_n low time in clk cycles; must be >= 1.
SETUP_CYCLES, 1, data_out valid before wr_n falls; must be >= 1.
HOLD_CYCLES, 1, recovery cycles with strobe high after each strobe; must be >= 1.

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
rxf_n  in  1  FIFO has data (low = byte available)
txe_n  in  1  FIFO can accept (low = space available)
data_in  in  8  FIFO read data bus
data_out  out  8  FIFO write data bus
data_out_enable  out  1  tristate enable for data_out at the pad
rd_n  out  1  FIFO read strobe
wr_n  out  1  FIFO write strobe
report_request  in  1  level request to send a report; held until report_done
report_data  in  4*NUM_GROUPS  panel switch values
cmd_data  out  8  captured command byte
cmd_valid  out  1  cmd_data holds an unconsumed byte
cmd_ready  in  1  consumer accepts cmd_data this cycle
report_done  out  1  one-cycle pulse when the last report byte completes
busy  out  1  high in any state other than IDLE
state_out  out  4  current state encoding, for debug

Behaviour:
- Reset: single clock domain; reset_n is asynchronous and active-low.
  - State goes to IDLE.
  - rd_n=1, wr_n=1, data_out_enable=0, data_out=0.
  - cmd_valid=0, cmd_data=0, report_done=0, busy=0, all counters=0.
  - Reset in mid-strobe releases rd_n/wr_n high immediately. No partial byte is kept.
- All FIFO outputs (rd_n, wr_n, data_out, data_out_enable) are registered; no combinational path from input to output.
- States: IDLE, RD_STROBE, RD_RECOVER, WR_WAIT, WR_SETUP, WR_STROBE, WR_HOLD, DONE. One shared down-counter times the multi-cycle states.
- IDLE arbitration, evaluated each cycle:
  - If report_request=1, go to WR_WAIT. Write has priority over read.
  - Else if rxf_n=0 and cmd_valid=0, go to RD_STROBE.
  - Else stay in IDLE.
- Read path:
  - RD_STROBE: rd_n=0 for exactly STROBE_CYCLES cycles.
  - data_in is captured into cmd_data on the clock edge that ends the strobe. cmd_valid=1 on that same edge, and rd_n returns to 1.
  - RD_RECOVER: HOLD_CYCLES cycles, then IDLE.
  - cmd_valid stays 1 until a cycle with cmd_ready=1, then clears on the next edge.
  - While cmd_valid=1 no new read starts: FIFO backpressure.
  - A cmd_ready and a capture in the same cycle cannot occur, because capture requires cmd_valid=0 at read start.
- Write path:
  - On entry to WR_WAIT from IDLE: snapshot report_data into an internal register, set byte index k=0, data_out_enable=1.
  - Byte k is {tag=k+1 (4 bits), snapshot[4k+3:4k]}. Tags run 1..NUM_GROUPS, so the host can resynchronise.
  - WR_WAIT: data_out=byte k, wr_n=1. Stay while txe_n=1; no timeout.
  - WR_SETUP: SETUP_CYCLES cycles.
  - WR_STROBE: wr_n=0 for STROBE_CYCLES cycles.
  - WR_HOLD: wr_n=1 with data held for HOLD_CYCLES cycles.
  - After WR_HOLD: if k<NUM_GROUPS-1, increment k and go to WR_WAIT; else go to DONE.
  - txe_n rising during WR_SETUP/STROBE/HOLD is ignored; the byte completes.
  - DONE (one cycle): report_done=1, data_out_enable=0, then IDLE.
  - report_request still 1 on return to IDLE starts a new report with a fresh snapshot; the requester must drop it on report_done.
  - Changes to report_data mid-report do not affect bytes already snapshotted.
- Minimum timings:
  - Read with defaults: 2+1 = 3 cycles, plus 1 cycle in IDLE.
  - Write byte with txe_n low: 1+SETUP+STROBE+HOLD = 5 cycles.
- Elaboration check: NUM_GROUPS outside 1..15, or any timing parameter < 1, is a fatal error.

Decomposition:
- Shared package usb_seq_pkg holds:
  - the state enumeration (4-bit, matches state_out);
  - TAG_W=4 and FIFO_DATA_W=8;
  - a function computing counter width from the max of the timing parameters.
- One natural sub-module, usb_strobe_timer: a loadable down-counter with load value, load, and expired outputs. It is shared by the read and write paths.

Test Plan:
- Read: rxf_n=0, data_in=8'hA5, cmd_ready=0.
  - Required: rd_n low exactly 2 cycles; cmd_data=A5 and cmd_valid=1 on the edge rd_n rises.
  - Required: no second rd_n while cmd_valid=1; cmd_ready=1 for one cycle clears cmd_valid and the next read starts.
- Report: report_data=16'h4321, txe_n=0.
  - Required: bytes 11,22,33,44 appear in order, each with wr_n low 2 cycles and data stable from WR_SETUP through WR_HOLD.
  - Required: report_done pulses once, 20 cycles after leaving IDLE.
- Priority: report_request=1 and rxf_n=0 in the same cycle -> write sequence first; the read follows after DONE.
- txe_n held high for 10 cycles before byte 3 -> wr_n stays high and byte 3 is held on data_out; the sequence resumes within 1 cycle of txe_n=0.
- Reset_n pulsed low during WR_STROBE of byte 2 -> wr_n=1 and data_out_enable=0 asynchronously; after release the block is in IDLE with no report_done.
- NUM_GROUPS=2, STROBE_CYCLES=3: report_data=8'hF0 -> bytes 10, 2F with wr_n low 3 cycles each.
